stf_detect: RTL and testbench

//  Receive-side detector for the 802.11 OFDM short training field (the 16-sample periodic preamble).

---
 rtl/stf_detect_pkg.sv | 27 ++
 rtl/sample_delay_line.sv | 28 ++
 rtl/stf_detect.sv | 202 ++++++++++++++++++++
 tb/tb_stf_detect.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/stf_detect_pkg.sv
// Shared constants, sample layout and FSM state type for the STF detector.
package stf_detect_pkg;

  localparam int LAG_DEF    = 16;
  localparam int WINDOW_DEF = 16;

  localparam int SAMPLE_W = 32;
  localparam int COMP_W   = 16;
  localparam int I_MSB    = 31;
  localparam int I_LSB    = 16;
  localparam int Q_MSB    = 15;
  localparam int Q_LSB    = 0;
  localparam int PROD_W   = 2 * COMP_W + 1;

  typedef enum logic [1:0] {
    WAIT_FILL = 2'd0,
    SEARCH    = 2'd1,
    PLATEAU   = 2'd2,
    LOCKED    = 2'd3
  } stf_state_t;

  // One guard bit so the sum or difference of two component products cannot wrap.
  function automatic logic signed [PROD_W-1:0] widen(input logic signed [2*COMP_W-1:0] p);
    return {p[2*COMP_W-1], p};
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Strobe-advanced shift register; dout is the word written DEPTH advances ago.
module sample_delay_line
  import stf_detect_pkg::*;
#(
  parameter int DEPTH = LAG_DEF,
  parameter int WIDTH = SAMPLE_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (advance) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/stf_detect.sv
// 802.11 STF detector: lag autocorrelation and window power, ratio test, plateau-count lock FSM.
module stf_detect
  import stf_detect_pkg::*;
#(
  parameter int LAG         = LAG_DEF,
  parameter int WINDOW      = WINDOW_DEF,
  parameter int THRESH      = 6,
  parameter int MIN_PLATEAU = 48,
  parameter int POWER_MIN   = 1024,
  parameter int ACC_W       = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  input  logic [31:0]       sample_in,
  input  logic              sample_in_strobe,
  output logic [ACC_W-1:0]  corr_mag,
  output logic [ACC_W-1:0]  power,
  output logic              metric_strobe,
  output logic              stf_detected,
  output logic              locked,
  output stf_state_t        state_dbg
);

  localparam int FILL_MAX = LAG + WINDOW;
  localparam int FILL_W   = $clog2(FILL_MAX + 1);
  localparam int PC_W     = $clog2(MIN_PLATEAU + 1);
  localparam int CMP_W    = ACC_W + 4;

  // Strobes are valid-only (no ready): a sample is taken on any clock where
  // sample_in_strobe && enable; every downstream stage carries its own valid bit.
  logic accept;
  assign accept = enable & sample_in_strobe;

  function automatic logic signed [ACC_W-1:0] to_acc(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  logic [SAMPLE_W-1:0] lag_out;
  sample_delay_line #(.DEPTH(LAG), .WIDTH(SAMPLE_W)) u_lag (
    .clock(clock), .reset(reset), .advance(accept), .din(sample_in), .dout(lag_out)
  );

  logic signed [COMP_W-1:0]   xi, xq, li, lq;
  logic signed [2*COMP_W-1:0] p_ii, p_qq, p_qi, p_iq, p_xx, p_yy;
  assign xi   = sample_in[I_MSB:I_LSB];
  assign xq   = sample_in[Q_MSB:Q_LSB];
  assign li   = lag_out[I_MSB:I_LSB];
  assign lq   = lag_out[Q_MSB:Q_LSB];
  assign p_ii = xi * li;
  assign p_qq = xq * lq;
  assign p_qi = xq * li;
  assign p_iq = xi * lq;
  assign p_xx = xi * xi;
  assign p_yy = xq * xq;

  // S1: products, plus whether this sample's metric is mature enough for the FSM
  logic                     s1_valid, s1_consider;
  logic signed [PROD_W-1:0] s1_re, s1_im, s1_pw;
  logic [FILL_W-1:0]        fill_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_consider <= 1'b0;
      s1_re       <= '0;
      s1_im       <= '0;
      s1_pw       <= '0;
      fill_cnt    <= '0;
    end else if (enable) begin
      s1_valid    <= accept;
      s1_consider <= accept && (fill_cnt >= FILL_W'(FILL_MAX - 1));
      if (accept) begin
        s1_re <= widen(p_ii) + widen(p_qq);
        s1_im <= widen(p_qi) - widen(p_iq);
        s1_pw <= widen(p_xx) + widen(p_yy);
        if (fill_cnt != FILL_W'(FILL_MAX)) fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  logic                       hist_adv;
  logic [2*PROD_W-1:0]        h_corr;
  logic [PROD_W-1:0]          h_pw;
  logic signed [PROD_W-1:0]   h_re, h_im, h_pws;
  assign hist_adv = enable & s1_valid;

  sample_delay_line #(.DEPTH(WINDOW), .WIDTH(2*PROD_W)) u_corr_hist (
    .clock(clock), .reset(reset), .advance(hist_adv), .din({s1_re, s1_im}), .dout(h_corr)
  );
  sample_delay_line #(.DEPTH(WINDOW), .WIDTH(PROD_W)) u_pow_hist (
    .clock(clock), .reset(reset), .advance(hist_adv), .din(s1_pw), .dout(h_pw)
  );

  assign h_re  = h_corr[2*PROD_W-1:PROD_W];
  assign h_im  = h_corr[PROD_W-1:0];
  assign h_pws = h_pw;

  // S2: running sums; wraparound is accepted, the accumulators never saturate
  logic                    s2_valid, s2_consider;
  logic signed [ACC_W-1:0] acc_re, acc_im, acc_pw;

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid    <= 1'b0;
      s2_consider <= 1'b0;
      acc_re      <= '0;
      acc_im      <= '0;
      acc_pw      <= '0;
    end else if (enable) begin
      s2_valid    <= s1_valid;
      s2_consider <= s1_consider;
      if (s1_valid) begin
        acc_re <= acc_re + to_acc(s1_re) - to_acc(h_re);
        acc_im <= acc_im + to_acc(s1_im) - to_acc(h_im);
        acc_pw <= acc_pw + to_acc(s1_pw) - to_acc(h_pws);
      end
    end
  end

  logic [ACC_W-1:0] abs_re, abs_im, mag_max, mag_min;
  always_comb begin
    abs_re  = acc_re[ACC_W-1] ? $unsigned(-acc_re) : $unsigned(acc_re);
    abs_im  = acc_im[ACC_W-1] ? $unsigned(-acc_im) : $unsigned(acc_im);
    mag_max = (abs_re >= abs_im) ? abs_re : abs_im;
    mag_min = (abs_re >= abs_im) ? abs_im : abs_re;
  end

  // S3: registered metric
  logic s3_consider;
  always_ff @(posedge clock) begin
    if (reset) begin
      corr_mag      <= '0;
      power         <= '0;
      metric_strobe <= 1'b0;
      s3_consider   <= 1'b0;
    end else if (enable) begin
      metric_strobe <= s2_valid;
      s3_consider   <= s2_consider;
      if (s2_valid) begin
        corr_mag <= mag_max + (mag_min >> 1);
        power    <= $unsigned(acc_pw);
      end
    end
  end

  logic [CMP_W-1:0] lhs, rhs;
  logic             qualify;
  always_comb begin
    lhs     = {1'b0, corr_mag, 3'b000};
    rhs     = CMP_W'(THRESH) * {4'b0000, power};
    qualify = (power >= ACC_W'(POWER_MIN)) && (lhs >= rhs);
  end

  stf_state_t       state;
  logic [PC_W-1:0]  plateau_cnt;
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= WAIT_FILL;
      plateau_cnt  <= '0;
      stf_detected <= 1'b0;
      locked       <= 1'b0;
    end else if (enable) begin
      stf_detected <= 1'b0;
      if (restart && (state == PLATEAU || state == LOCKED)) begin
        state       <= SEARCH;
        plateau_cnt <= '0;
        locked      <= 1'b0;
      end else if (metric_strobe && s3_consider) begin
        case (state)
          // The first mature metric is already scored, so lock can land on sample LAG+WINDOW-1+MIN_PLATEAU-1.
          WAIT_FILL, SEARCH: begin
            if (qualify) begin
              state       <= PLATEAU;
              plateau_cnt <= PC_W'(1);
            end else begin
              state       <= SEARCH;
              plateau_cnt <= '0;
            end
          end
          PLATEAU: begin
            if (!qualify) begin
              state       <= SEARCH;
              plateau_cnt <= '0;
            end else if (plateau_cnt == PC_W'(MIN_PLATEAU - 1)) begin
              state        <= LOCKED;
              locked       <= 1'b1;
              stf_detected <= 1'b1;
            end else begin
              plateau_cnt <= plateau_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stf_detect.sv
// Directed bench for stf_detect: reset, lock timing, strobe gaps, noise, zeros, restart and mid-run reset.
module tb_stf_detect;
  import stf_detect_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        restart = 1'b0;
  logic        sample_in_strobe = 1'b0;
  logic [31:0] sample_in = '0;
  logic [39:0] corr_mag, power;
  logic        metric_strobe, stf_detected, locked;
  stf_state_t  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ms_cnt = 0;
  int det_cnt = 0;
  int det_cyc = -1;
  int mark_idx = -1;
  int mark_cyc = -100;
  bit lock_seen = 1'b0;

  logic [15:0] pat_i = 16'hB2E5;
  logic [15:0] pat_q = 16'h6D1A;
  logic [31:0] lfsr  = 32'hACE12345;

  localparam logic [39:0] STF_POWER = 40'd536870912;

  stf_detect dut (
    .clock(clock), .reset(reset), .enable(enable), .restart(restart),
    .sample_in(sample_in), .sample_in_strobe(sample_in_strobe),
    .corr_mag(corr_mag), .power(power), .metric_strobe(metric_strobe),
    .stf_detected(stf_detected), .locked(locked), .state_dbg(state_dbg)
  );

  // clock / cycle counter / event counters
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (metric_strobe) ms_cnt++;
    if (stf_detected) begin
      det_cnt++;
      det_cyc = cyc;
    end
    if (locked) lock_seen = 1'b1;
  end

  // 16-periodic QPSK pattern at amplitude 4096: corr equals power once the lag line is full
  function automatic logic [31:0] stf_sample(input int n);
    logic [15:0] i_v, q_v;
    i_v = pat_i[n % 16] ? 16'd4096 : 16'hF000;
    q_v = pat_q[n % 16] ? 16'd4096 : 16'hF000;
    return {i_v, q_v};
  endfunction

  task automatic next_noise(output logic [31:0] s);
    logic [15:0] mi, mq;
    lfsr ^= lfsr << 13;
    lfsr ^= lfsr >> 17;
    lfsr ^= lfsr << 5;
    mi = 16'd16384 + {2'b00, lfsr[13:0]};
    mq = 16'd16384 + {2'b00, lfsr[29:16]};
    s  = {lfsr[14] ? -mi : mi, lfsr[30] ? -mq : mq};
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_counters();
    ms_cnt    = 0;
    det_cnt   = 0;
    det_cyc   = -1;
    mark_cyc  = -100;
    lock_seen = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    restart = 1'b0;
    sample_in_strobe = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_counters();
  endtask

  task automatic feed(input int first, input int count, input int gap, input bit noise, input logic zero);
    for (int k = first; k < first + count; k++) begin
      if (zero) sample_in = '0;
      else if (noise) next_noise(sample_in);
      else sample_in = stf_sample(k);
      sample_in_strobe = 1'b1;
      if (k == mark_idx) mark_cyc = cyc;
      tick();
      sample_in_strobe = 1'b0;
      for (int g = 1; g < gap; g++) tick();
    end
  endtask

  task automatic drain();
    repeat (6) tick();
  endtask

  // scenarios
  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      sample_in        = $urandom;
      sample_in_strobe = 1'($urandom_range(0, 1));
      restart          = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    checks++; if (corr_mag !== 40'd0) begin errors++; $display("FAIL reset_corr: got %0d expected 0", corr_mag); end
    checks++; if (power !== 40'd0) begin errors++; $display("FAIL reset_power: got %0d expected 0", power); end
    checks++; if (metric_strobe !== 1'b0) begin errors++; $display("FAIL reset_ms: got %b expected 0", metric_strobe); end
    checks++; if (stf_detected !== 1'b0) begin errors++; $display("FAIL reset_det: got %b expected 0", stf_detected); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (state_dbg !== WAIT_FILL) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, WAIT_FILL); end
    tick();
    do_reset();
  endtask

  task automatic test_stf_lock(input int gap);
    do_reset();
    mark_idx = 78;
    feed(0, 160, gap, 1'b0, 1'b0);
    drain();
    checks++; if (det_cnt !== 1) begin errors++; $display("FAIL lock_pulses gap%0d: got %0d expected 1", gap, det_cnt); end
    checks++; if (det_cyc - mark_cyc !== 4) begin errors++; $display("FAIL lock_latency gap%0d: got %0d expected 4", gap, det_cyc - mark_cyc); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_level gap%0d: got %b expected 1", gap, locked); end
    checks++; if (ms_cnt !== 160) begin errors++; $display("FAIL lock_metric_count gap%0d: got %0d expected 160", gap, ms_cnt); end
    checks++; if (power !== STF_POWER) begin errors++; $display("FAIL lock_power gap%0d: got %0d expected %0d", gap, power, STF_POWER); end
    checks++; if (corr_mag !== STF_POWER) begin errors++; $display("FAIL lock_corr gap%0d: got %0d expected %0d", gap, corr_mag, STF_POWER); end
    checks++; if (state_dbg !== LOCKED) begin errors++; $display("FAIL lock_state gap%0d: got %0d expected %0d", gap, state_dbg, LOCKED); end
  endtask

  task automatic test_enable();
    do_reset();
    mark_idx = -1;
    enable = 1'b0;
    feed(0, 20, 1, 1'b0, 1'b0);
    enable = 1'b1;
    drain();
    checks++; if (ms_cnt !== 0) begin errors++; $display("FAIL enable_ms: got %0d expected 0", ms_cnt); end
    checks++; if (power !== 40'd0) begin errors++; $display("FAIL enable_power: got %0d expected 0", power); end
    checks++; if (state_dbg !== WAIT_FILL) begin errors++; $display("FAIL enable_state: got %0d expected %0d", state_dbg, WAIT_FILL); end
  endtask

  task automatic test_noise();
    do_reset();
    mark_idx = -1;
    feed(0, 70, 1, 1'b0, 1'b0);
    feed(70, 500, 1, 1'b1, 1'b0);
    drain();
    checks++; if (lock_seen !== 1'b0) begin errors++; $display("FAIL noise_locked: got %b expected 0", lock_seen); end
    checks++; if (det_cnt !== 0) begin errors++; $display("FAIL noise_det: got %0d expected 0", det_cnt); end
    checks++; if (ms_cnt !== 570) begin errors++; $display("FAIL noise_metric_count: got %0d expected 570", ms_cnt); end
  endtask

  task automatic test_zero();
    do_reset();
    mark_idx = -1;
    feed(0, 1000, 1, 1'b0, 1'b1);
    drain();
    checks++; if (power !== 40'd0) begin errors++; $display("FAIL zero_power: got %0d expected 0", power); end
    checks++; if (corr_mag !== 40'd0) begin errors++; $display("FAIL zero_corr: got %0d expected 0", corr_mag); end
    checks++; if (lock_seen !== 1'b0) begin errors++; $display("FAIL zero_locked: got %b expected 0", lock_seen); end
    checks++; if (state_dbg !== SEARCH) begin errors++; $display("FAIL zero_state: got %0d expected %0d", state_dbg, SEARCH); end
  endtask

  task automatic test_restart();
    do_reset();
    mark_idx = -1;
    feed(0, 100, 1, 1'b0, 1'b0);
    drain();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL restart_prelock: got %b expected 1", locked); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL restart_drop: got %b expected 0", locked); end
    checks++; if (state_dbg !== SEARCH) begin errors++; $display("FAIL restart_state: got %0d expected %0d", state_dbg, SEARCH); end
    clear_counters();
    mark_idx = 147;
    feed(100, 48, 1, 1'b0, 1'b0);
    drain();
    checks++; if (det_cnt !== 1) begin errors++; $display("FAIL relock_pulses: got %0d expected 1", det_cnt); end
    checks++; if (det_cyc - mark_cyc !== 4) begin errors++; $display("FAIL relock_latency: got %0d expected 4", det_cyc - mark_cyc); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_level: got %b expected 1", locked); end
  endtask

  task automatic test_reset_plateau();
    do_reset();
    mark_idx = -1;
    feed(0, 61, 1, 1'b0, 1'b0);
    checks++; if (state_dbg !== PLATEAU) begin errors++; $display("FAIL midreset_pre_state: got %0d expected %0d", state_dbg, PLATEAU); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_counters();
    checks++; if (state_dbg !== WAIT_FILL) begin errors++; $display("FAIL midreset_state: got %0d expected %0d", state_dbg, WAIT_FILL); end
    drain();
    checks++; if (ms_cnt !== 0) begin errors++; $display("FAIL midreset_inflight: got %0d expected 0", ms_cnt); end
    checks++; if (power !== 40'd0) begin errors++; $display("FAIL midreset_power: got %0d expected 0", power); end
    mark_idx = 78;
    feed(0, 160, 1, 1'b0, 1'b0);
    drain();
    checks++; if (det_cnt !== 1) begin errors++; $display("FAIL midreset_relock_pulses: got %0d expected 1", det_cnt); end
    checks++; if (det_cyc - mark_cyc !== 4) begin errors++; $display("FAIL midreset_relock_latency: got %0d expected 4", det_cyc - mark_cyc); end
  endtask

  initial begin
    test_reset();
    test_stf_lock(1);
    test_stf_lock(4);
    test_enable();
    test_noise();
    test_zero();
    test_restart();
    test_reset_plateau();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
